// File: rtl/ifu_fetch_queue_if.sv
// ----------------------------------------------------------------------------
// Module      : ifu_fetch_queue_if
// Description : Fetch-queue bus bundle: imem port, redirect and decode handshake.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface ifu_fetch_queue_if #(
  parameter int INSTR_SIZE = 32
);
  logic                  imem_req;
  logic [31:0]           imem_addr;
  logic [INSTR_SIZE-1:0] imem_rdata;
  logic                  redirect_valid;
  logic [31:0]           redirect_pc;
  logic                  if_valid;
  logic                  if_ready;
  logic [INSTR_SIZE-1:0] if_instr;
  logic [31:0]           if_pc;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc,
    input  imem_rdata, redirect_valid, redirect_pc, if_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc,
    output imem_rdata, redirect_valid, redirect_pc, if_ready
  );
endinterface

`default_nettype wire

// File: rtl/ifu_fetch_queue.sv
// ----------------------------------------------------------------------------
// Module      : ifu_fetch_queue
// Description : Sequential instruction fetch with credit-limited queue to decode.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module ifu_fetch_queue #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          INSTR_SIZE = 32
) (
  input  wire logic          sys_clk,
  input  wire logic          sys_rst_n,
  ifu_fetch_queue_if.master  bus
);

  localparam int                 c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int                 c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W:0]   c_DEPTH = (c_CNT_W + 1)'(FIFO_DEPTH);

  logic [31:0]           r_pc;
  logic [31:0]           r_req_pc;
  logic                  r_run;
  logic                  r_inflight;
  logic [c_PTR_W-1:0]    r_wr_ptr;
  logic [c_PTR_W-1:0]    r_rd_ptr;
  logic [c_CNT_W-1:0]    r_count;
  logic [31:0]           r_pc_mem    [FIFO_DEPTH];
  logic [INSTR_SIZE-1:0] r_instr_mem [FIFO_DEPTH];

  logic w_redirect;
  logic w_credit;
  logic w_issue;
  logic w_push;
  logic w_pop;
  logic w_unused;

  assign w_redirect = bus.redirect_valid & r_run;
  // Credits use registered occupancy only; a pop this cycle frees a slot next cycle.
  assign w_credit   = ({1'b0, r_count} + {{c_CNT_W{1'b0}}, r_inflight}) < c_DEPTH;
  assign w_issue    = r_run & ~bus.redirect_valid & w_credit;
  assign w_push     = r_inflight & ~w_redirect;
  assign w_pop      = (r_count != '0) & bus.if_ready & ~w_redirect;
  assign w_unused   = ^bus.redirect_pc[1:0];

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_pc       <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_run      <= 1'b0;
      r_inflight <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_run <= 1'b1;
      if (w_redirect) begin
        r_pc       <= {bus.redirect_pc[31:2], 2'b00};
        r_inflight <= 1'b0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_count    <= '0;
      end else begin
        if (w_issue) begin
          r_pc     <= r_pc + 32'd4;
          r_req_pc <= r_pc;
        end
        r_inflight <= w_issue;
        if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + c_CNT_W'(1);
          2'b01:   r_count <= r_count - c_CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Queue storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge sys_clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]    <= r_req_pc;
      r_instr_mem[r_wr_ptr] <= bus.imem_rdata;
    end
  end

  assign bus.imem_req  = w_issue;
  assign bus.imem_addr = r_pc;
  assign bus.if_valid  = (r_count != '0);
  assign bus.if_instr  = r_instr_mem[r_rd_ptr];
  assign bus.if_pc     = r_pc_mem[r_rd_ptr];

endmodule

`default_nettype wire
